// File: rtl/qam_symbol_mapper.sv
// Serial-bit to Gray-mapped I/Q symbol source (BPSK/QPSK/16QAM/64QAM).
// Ports: clk, rst_n, enable, mod_type, baud_rate, bit_in/valid/ready,
//        sym_i, sym_q, sym_valid, underflow.
module qam_symbol_mapper #(
  parameter int CLK_HZ    = 11059200,
  parameter int BAUD_BASE = 2400,
  parameter int IQ_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             mod_type,
  input  logic [1:0]             baud_rate,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic signed [IQ_W-1:0] sym_i,
  output logic signed [IQ_W-1:0] sym_q,
  output logic                   sym_valid,
  output logic                   underflow
);

  localparam int DIV   = CLK_HZ / BAUD_BASE;
  localparam int CW    = $clog2(DIV + 1);
  localparam int AMAX  = (1 << (IQ_W - 1)) - 1;
  localparam int STEP3 = AMAX / 3;
  localparam int STEP7 = AMAX / 7;
  localparam int PW    = IQ_W + 6;

  logic [1:0]             mode_q, mode_d;
  logic [1:0]             rate_q, rate_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [5:0]             sr_q, sr_d;
  logic [2:0]             fill_q, fill_d;
  logic signed [IQ_W-1:0] si_q, si_d;
  logic signed [IQ_W-1:0] sq_q, sq_d;
  logic                   vld_q, vld_d;
  logic                   uf_q, uf_d;

  logic [CW-1:0]          period;
  logic                   tick;
  logic [2:0]             bps;
  logic                   take;
  logic [5:0]             sr_nx;
  logic [2:0]             fill_nx;
  logic [2:0]             gi, gq;
  logic [1:0]             nb;
  logic                   q_off;
  logic [IQ_W-1:0]        step;
  logic signed [4:0]      lvl_i, lvl_q;
  logic signed [PW-1:0]   prod_i, prod_q;

  // Gray word (right-aligned, zero-padded) to odd level 2*bin-(2^n-1).
  // Prefix-XOR from the top bit works for any n since padding is 0.
  function automatic logic signed [4:0] gray_lvl(
    input logic [2:0] g,
    input logic [1:0] n
  );
    logic [2:0]        b;
    logic signed [4:0] two_b;
    logic signed [4:0] lmax;
    b[2]  = g[2];
    b[1]  = b[2] ^ g[1];
    b[0]  = b[1] ^ g[0];
    two_b = $signed({1'b0, b, 1'b0});
    unique case (1'b1)
      (n == 2'd1): lmax = 5'sd1;
      (n == 2'd2): lmax = 5'sd3;
      default:     lmax = 5'sd7;
    endcase
    return two_b - lmax;
  endfunction

  always_comb begin
    period  = CW'(DIV) >> rate_q;
    tick    = enable && (cnt_q == period - CW'(1));
    unique case (1'b1)
      (mode_q == 2'd0): bps = 3'd1;
      (mode_q == 2'd1): bps = 3'd2;
      (mode_q == 2'd2): bps = 3'd4;
      default:          bps = 3'd6;
    endcase
    bit_ready = enable && (fill_q < bps);
    take      = bit_valid && bit_ready;
    sr_nx     = take ? {sr_q[4:0], bit_in} : sr_q;
    fill_nx   = fill_q + {2'b00, take};
  end

  // First-accepted bit sits highest, so b0 is sr_nx[bps-1].
  always_comb begin
    gi    = '0;
    gq    = '0;
    nb    = 2'd1;
    q_off = 1'b0;
    step  = IQ_W'(AMAX);
    unique case (1'b1)
      (mode_q == 2'd0): begin
        gi    = {2'b00, sr_nx[0]};
        q_off = 1'b1;
      end
      (mode_q == 2'd1): begin
        gi = {2'b00, sr_nx[1]};
        gq = {2'b00, sr_nx[0]};
      end
      (mode_q == 2'd2): begin
        gi   = {1'b0, sr_nx[3:2]};
        gq   = {1'b0, sr_nx[1:0]};
        nb   = 2'd2;
        step = IQ_W'(STEP3);
      end
      default: begin
        gi   = sr_nx[5:3];
        gq   = sr_nx[2:0];
        nb   = 2'd3;
        step = IQ_W'(STEP7);
      end
    endcase
    lvl_i  = gray_lvl(gi, nb);
    lvl_q  = q_off ? 5'sd0 : gray_lvl(gq, nb);
    prod_i = PW'(lvl_i) * PW'($signed({1'b0, step}));
    prod_q = PW'(lvl_q) * PW'($signed({1'b0, step}));
  end

  always_comb begin
    mode_d = mode_q;
    rate_d = rate_q;
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    fill_d = fill_q;
    si_d   = si_q;
    sq_d   = sq_q;
    vld_d  = 1'b0;
    uf_d   = 1'b0;
    if (!enable) begin
      mode_d = mod_type;
      rate_d = baud_rate;
      cnt_d  = '0;
      sr_d   = '0;
      fill_d = '0;
    end else begin
      cnt_d  = tick ? '0 : cnt_q + CW'(1);
      sr_d   = sr_nx;
      fill_d = fill_nx;
      if (tick) begin
        vld_d = 1'b1;
        if (fill_nx == bps) begin
          fill_d = '0;
          si_d   = prod_i[IQ_W-1:0];
          sq_d   = prod_q[IQ_W-1:0];
        end else begin
          // Partial bits stay buffered for the next tick.
          uf_d = 1'b1;
          si_d = '0;
          sq_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      rate_q <= '0;
      cnt_q  <= '0;
      sr_q   <= '0;
      fill_q <= '0;
      si_q   <= '0;
      sq_q   <= '0;
      vld_q  <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      fill_q <= fill_d;
      si_q   <= si_d;
      sq_q   <= sq_d;
      vld_q  <= vld_d;
      uf_q   <= uf_d;
    end
  end

  assign sym_i     = si_q;
  assign sym_q     = sq_q;
  assign sym_valid = vld_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Bench for qam_symbol_mapper: default IQ_W=16 and IQ_W=12 copies share
// stimulus; a queue-based model is checked every cycle plus literals.
module tb_qam_symbol_mapper;

  localparam int DIV = 11059200 / 2400;
  localparam int A16 = 32767;
  localparam int A12 = 2047;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [1:0]         mod_type = 2'd2;
  logic [1:0]         baud_rate = 2'd0;
  logic               bit_in = 1'b0;
  logic               bit_valid = 1'b0;
  logic               bit_ready, bit_ready12;
  logic signed [15:0] sym_i, sym_q;
  logic signed [11:0] s12_i, s12_q;
  logic               sym_valid, underflow;
  logic               v12, uf12;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qam_symbol_mapper dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mod_type(mod_type), .baud_rate(baud_rate),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_i(sym_i), .sym_q(sym_q),
    .sym_valid(sym_valid), .underflow(underflow)
  );

  qam_symbol_mapper #(.IQ_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mod_type(mod_type), .baud_rate(baud_rate),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready12),
    .sym_i(s12_i), .sym_q(s12_q),
    .sym_valid(v12), .underflow(uf12)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int bps_t[4]  = '{1, 2, 4, 6};
  int lmax_t[4] = '{1, 1, 3, 7};
  int lv2[4]    = '{-3, -1, 3, 1};
  int lv3[8]    = '{-7, -5, -1, -3, 7, 5, 1, 3};

  int m_mode, m_rate, m_ph, m_lmax, m_li, m_lq;
  int m_vld, m_uf;
  int bitq[$];
  logic s_rst, s_en, s_bv, s_bi;
  logic [1:0] s_mt, s_br;

  task automatic model_reset();
    m_mode = 0; m_rate = 0; m_ph = 0; m_lmax = 1;
    m_li = 0; m_lq = 0; m_vld = 0; m_uf = 0;
    bitq.delete();
  endtask

  task automatic model_step();
    int n, bps;
    bit tick;
    m_vld = 0;
    m_uf  = 0;
    if (!s_en) begin
      m_mode = s_mt;
      m_rate = s_br;
      m_ph   = 0;
      bitq.delete();
      return;
    end
    bps = bps_t[m_mode];
    if (s_bv && bitq.size() < bps) bitq.push_back(int'(s_bi));
    n    = DIV >> m_rate;
    m_ph = m_ph + 1;
    tick = (m_ph == n);
    if (!tick) return;
    m_ph  = 0;
    m_vld = 1;
    if (bitq.size() == bps) begin
      m_lmax = lmax_t[m_mode];
      case (m_mode)
        0: begin m_li = bitq[0] ? 1 : -1; m_lq = 0; end
        1: begin m_li = bitq[0] ? 1 : -1; m_lq = bitq[1] ? 1 : -1; end
        2: begin
          m_li = lv2[2*bitq[0] + bitq[1]];
          m_lq = lv2[2*bitq[2] + bitq[3]];
        end
        default: begin
          m_li = lv3[4*bitq[0] + 2*bitq[1] + bitq[2]];
          m_lq = lv3[4*bitq[3] + 2*bitq[4] + bitq[5]];
        end
      endcase
      bitq.delete();
    end else begin
      m_uf = 1;
      m_li = 0;
      m_lq = 0;
    end
  endtask

  initial begin
    int exp_rdy;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      s_rst = rst_n; s_en = enable; s_bv = bit_valid; s_bi = bit_in;
      s_mt = mod_type; s_br = baud_rate;
      exp_rdy = (s_rst && s_en && bitq.size() < bps_t[m_mode]) ? 1 : 0;
      chk("m_ready", int'(bit_ready), exp_rdy);
      chk("m_ready12", int'(bit_ready12), exp_rdy);
      @(posedge clk);
      #1;
      if (!s_rst) model_reset();
      else model_step();
      chk("m_valid", int'(sym_valid), m_vld);
      chk("m_uflow", int'(underflow), m_uf);
      chk("m_i", int'(sym_i), m_li * (A16 / m_lmax));
      chk("m_q", int'(sym_q), m_lq * (A16 / m_lmax));
      chk("m_valid12", int'(v12), m_vld);
      chk("m_uflow12", int'(uf12), m_uf);
      chk("m_i12", int'(s12_i), m_li * (A12 / m_lmax));
      chk("m_q12", int'(s12_q), m_lq * (A12 / m_lmax));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_sym(input int start, input int max, output int k);
    bit done;
    k = start;
    done = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      k++;
      if (sym_valid) done = 1;
      else if (k - start >= max) begin
        chk("sym_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  task automatic restart(input logic [1:0] mt, input logic [1:0] br);
    @(negedge clk);
    enable    = 1'b0;
    bit_valid = 1'b0;
    mod_type  = mt;
    baud_rate = br;
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    int k;
    logic b;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(sym_valid), 0);
    chk("rst_uflow", int'(underflow), 0);
    chk("rst_i", int'(sym_i), 0);
    chk("rst_q", int'(sym_q), 0);
    chk("rst_ready", int'(bit_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 16QAM 1x, bits 1,0,0,1
    @(negedge clk);
    enable = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    chk("ready_full", int'(bit_ready), 0);
    wait_sym(5, 5000, k);
    chk("first_lat", k, 4609);
    chk("q16_i", int'(sym_i), 32766);
    chk("q16_q", int'(sym_q), -10922);
    chk("q16_i12", int'(s12_i), 2046);
    chk("q16_q12", int'(s12_q), -682);
    chk("q16_uf", int'(underflow), 0);
    chk("ready_back", int'(bit_ready), 1);
    wait_sym(0, 5000, k);
    chk("spacing", k, 4608);
    chk("q16_uf2", int'(underflow), 1);
    chk("q16_zero", int'(sym_i), 0);

    // 64QAM 8x, bits 1,0,0,0,1,0
    restart(2'd3, 2'd3);
    bit_valid = 1'b1; bit_in = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    wait_sym(7, 700, k);
    chk("q64_lat", k, 577);
    chk("q64_i", int'(sym_i), 32767);
    chk("q64_q", int'(sym_q), -4681);
    chk("q64_i12", int'(s12_i), 2044);
    chk("q64_q12", int'(s12_q), -292);

    // QPSK 8x starved, then split bits across a tick
    restart(2'd1, 2'd3);
    wait_sym(1, 700, k);
    chk("qp_lat", k, 577);
    chk("qp_uf1", int'(underflow), 1);
    wait_sym(0, 700, k);
    chk("qp_space", k, 576);
    chk("qp_uf2", int'(underflow), 1);
    drive_bit(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    wait_sym(0, 700, k);
    chk("qp_uf3", int'(underflow), 1);
    drive_bit(1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    wait_sym(0, 700, k);
    chk("qp_uf4", int'(underflow), 0);
    chk("qp_i", int'(sym_i), 32767);
    chk("qp_q", int'(sym_q), -32767);

    // BPSK bit arriving on the tick cycle itself
    for (int t = 0; t < 2; t++) begin
      b = (t == 0);
      restart(2'd0, 2'd3);
      repeat (575) @(negedge clk);
      bit_valid = 1'b1;
      bit_in = b;
      @(posedge clk);
      #1;
      chk("bp_valid", int'(sym_valid), 1);
      chk("bp_uf", int'(underflow), 0);
      chk("bp_i", int'(sym_i), b ? 32767 : -32767);
      chk("bp_q", int'(sym_q), 0);
      @(negedge clk);
      bit_valid = 1'b0;
    end

    // mod_type ignored while enabled
    @(negedge clk);
    mod_type = 2'd3; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    wait_sym(0, 700, k);
    chk("hold_uf", int'(underflow), 0);
    chk("hold_i", int'(sym_i), 32767);
    chk("hold_q", int'(sym_q), 0);

    // one idle cycle picks up the new mode and restarts the divider
    restart(2'd1, 2'd3);
    bit_valid = 1'b1; bit_in = 1'b1;
    drive_bit(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    wait_sym(3, 700, k);
    chk("new_lat", k, 577);
    chk("new_i", int'(sym_i), 32767);
    chk("new_q", int'(sym_q), 32767);
    chk("new_q12", int'(s12_q), 2047);

    // disable drops the buffered partial bit, keeps last I/Q
    drive_bit(1'b1);
    @(negedge clk);
    bit_valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk("keep_i", int'(sym_i), 32767);
    wait_sym(1, 700, k);
    chk("clr_lat", k, 577);
    chk("clr_uf", int'(underflow), 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
